// File: rtl/optq_pkg.sv
// Shared types and constants for the optical RX byte queue / UART launch scheduler.
package optq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } optq_state_e;

  localparam int unsigned GAP_CNT_W  = 16;
  localparam int unsigned DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/optq_fifo_mem.sv
// Byte FIFO storage with registered level/full/empty; caller must not push when full.
module optq_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_c,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;

  assign head_c = mem[rd_ptr];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/optical_rx_uart_queue.sv
// Buffers optical RX bytes and launches them one at a time into a UART transmitter.
// Optional drop counter port enabled by defining OPTQ_DROP_CNT_EN.
module optical_rx_uart_queue
  import optq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  input  logic          tx_done,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow
`ifdef OPTQ_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  optq_state_e          state;
  optq_state_e          state_next;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt_next;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;
  logic [7:0]           head_c;

  // full is the pre-pop registered flag, so a same-cycle pop never rescues a push.
  assign push_c = rx_valid & ~full;
  assign drop_c = rx_valid & full;

  optq_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (rx_byte),
    .pop       (pop_c),
    .head_c    (head_c),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    pop_c        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop_c      = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          gap_cnt_next = '0;
          state_next   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1)) state_next = IDLE;
        else gap_cnt_next = gap_cnt + GAP_CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      tx_wr    <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
      tx_wr   <= (state_next == LAUNCH);
      if (pop_c)  tx_data  <= head_c;
      if (drop_c) overflow <= 1'b1;
    end
  end

`ifdef OPTQ_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (drop_c && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end
`endif

endmodule
